// File: rtl/enemy_shot_pkg.sv
// rtl/enemy_shot_pkg.sv - grid geometry, screen size and shot FSM states
// Shared with the enemy grid and player ammunition blocks.
package enemy_shot_pkg;
  localparam int GRID_X0   = 180;
  localparam int GRID_DX   = 80;
  localparam int GRID_Y0   = 40;
  localparam int GRID_DY   = 50;
  localparam int GRID_COLS = 8;
  localparam int GRID_ROWS = 3;
  localparam int SCREEN_H  = 480;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    FLY,
    HIT
  } state_t;
endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign out = r_lfsr;
endmodule

// File: rtl/enemy_shot.sv
// rtl/enemy_shot.sv - enemy downward shot: column pick, flight, player hit, pixel colour
// One shot at a time; spawned under the lowest living enemy of a random living column.
module enemy_shot
  import enemy_shot_pkg::*;
#(
  parameter int          ENEMY_W         = 40,
  parameter int          ENEMY_H         = 30,
  parameter int          SHOT_W          = 4,
  parameter int          SHOT_H          = 12,
  parameter int          SHOT_SPEED      = 4,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter int          PLAYER_Y        = 440,
  parameter int          PLAYER_W        = 40,
  parameter int          PLAYER_H        = 20,
  parameter logic [23:0] COLOR           = 24'hFF4040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic [23:0] vivo_inimigo,
  input  logic        vivo_jogador,
  input  logic [9:0]  posX_Nave,
  output logic        tiro_ativo_inimigo,
  output logic [9:0]  posX_Municao2,
  output logic [9:0]  posY_Municao2,
  output logic        hit_jogador,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);
  state_t      r_state;
  logic [15:0] r_cool;
  logic [2:0]  r_col;
  logic [2:0]  r_scan;
  logic [9:0]  r_posx;
  logic [9:0]  r_posy;
  logic        r_active;
  logic        r_hit;
  logic [9:0]  r_v_prev;
  logic [23:0] r_rgb;

  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;
  logic        w_tick;
  logic [2:0]  w_col_rows;
  logic [1:0]  w_row;
  logic [9:0]  w_spawn_x;
  logic [9:0]  w_spawn_y;
  logic [10:0] w_x11;
  logic [10:0] w_nave11;
  logic [10:0] w_y_next;
  logic        w_bottom;
  logic        w_overlap;
  logic        w_in_shot;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (w_lfsr)
  );
  assign w_unused_lfsr = ^w_lfsr[15:3];

  // Edge-detect the first line of vertical blanking so the tick is one clk wide.
  assign w_tick = (v_counter == 10'(SCREEN_H)) && (r_v_prev != 10'(SCREEN_H));

  always_comb begin
    w_col_rows = {vivo_inimigo[{2'd2, r_col}], vivo_inimigo[{2'd1, r_col}],
                  vivo_inimigo[{2'd0, r_col}]};
    if (w_col_rows[2])      w_row = 2'd2;
    else if (w_col_rows[1]) w_row = 2'd1;
    else                    w_row = 2'd0;
  end

  assign w_spawn_x = 10'(GRID_X0 + ENEMY_W / 2 - SHOT_W / 2) + 10'(r_col) * 10'(GRID_DX);
  assign w_spawn_y = 10'(GRID_Y0 + ENEMY_H) + 10'(w_row) * 10'(GRID_DY);

  // 11-bit arithmetic keeps the bottom-edge and overlap compares free of wrap.
  assign w_x11     = {1'b0, r_posx};
  assign w_nave11  = {1'b0, posX_Nave};
  assign w_y_next  = {1'b0, r_posy} + 11'(SHOT_SPEED);
  assign w_bottom  = w_y_next >= 11'(SCREEN_H);
  assign w_overlap = (w_x11 < w_nave11 + 11'(PLAYER_W)) &&
                     (w_x11 + 11'(SHOT_W) > w_nave11) &&
                     (w_y_next < 11'(PLAYER_Y + PLAYER_H)) &&
                     (w_y_next + 11'(SHOT_H) > 11'(PLAYER_Y));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cool   <= 16'(COOLDOWN_FRAMES);
      r_col    <= 3'd0;
      r_scan   <= 3'd0;
      r_posx   <= 10'd0;
      r_posy   <= 10'd0;
      r_active <= 1'b0;
      r_hit    <= 1'b0;
      r_v_prev <= 10'd0;
    end else begin
      r_v_prev <= v_counter;
      r_hit    <= 1'b0;
      if (!vivo_jogador) begin
        r_state  <= IDLE;
        r_active <= 1'b0;
        r_cool   <= 16'(COOLDOWN_FRAMES);
      end else begin
        case (r_state)
          IDLE: begin
            if (w_tick) begin
              if (r_cool <= 16'd1) begin
                r_state <= SELECT;
                r_col   <= w_lfsr[2:0];
                r_scan  <= 3'd0;
              end else begin
                r_cool <= r_cool - 16'd1;
              end
            end
          end
          SELECT: begin
            if (|w_col_rows) begin
              r_posx   <= w_spawn_x;
              r_posy   <= w_spawn_y;
              r_active <= 1'b1;
              r_state  <= FLY;
            end else if (r_scan == 3'd7) begin
              r_state <= IDLE;
              r_cool  <= 16'(COOLDOWN_FRAMES);
            end else begin
              r_scan <= r_scan + 3'd1;
              r_col  <= r_col + 3'd1;
            end
          end
          FLY: begin
            if (w_tick) begin
              if (w_bottom) begin
                r_state  <= IDLE;
                r_active <= 1'b0;
                r_cool   <= 16'(COOLDOWN_FRAMES);
              end else begin
                r_posy <= w_y_next[9:0];
                if (w_overlap) r_state <= HIT;
              end
            end
          end
          HIT: begin
            r_hit    <= 1'b1;
            r_active <= 1'b0;
            r_cool   <= 16'(COOLDOWN_FRAMES);
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Gating on vivo_jogador blanks the shot on the same edge the block is forced idle.
  assign w_in_shot = r_active && vivo_jogador &&
                     ({1'b0, h_counter} >= w_x11) &&
                     ({1'b0, h_counter} < w_x11 + 11'(SHOT_W)) &&
                     ({1'b0, v_counter} >= {1'b0, r_posy}) &&
                     ({1'b0, v_counter} < {1'b0, r_posy} + 11'(SHOT_H));

  always_ff @(posedge clk) begin
    if (reset)          r_rgb <= 24'h0;
    else if (w_in_shot) r_rgb <= COLOR;
    else                r_rgb <= 24'h0;
  end

  assign tiro_ativo_inimigo = r_active;
  assign posX_Municao2      = r_posx;
  assign posY_Municao2      = r_posy;
  assign hit_jogador        = r_hit;
  assign R                  = r_rgb[23:16];
  assign G                  = r_rgb[15:8];
  assign B                  = r_rgb[7:0];
endmodule

// File: tb/tb_enemy_shot.sv
// tb/tb_enemy_shot.sv - scoreboard bench for enemy_shot with a frame-level reference model
module tb_enemy_shot;
  localparam int CD    = 60;
  localparam int SH    = 480;
  localparam int SPEED = 4;
  localparam int SW    = 4;
  localparam int SHH   = 12;
  localparam int PY    = 440;
  localparam int PW    = 40;
  localparam int PH    = 20;
  localparam int COLR  = 24'hFF4040;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_counter;
  logic [9:0]  v_counter;
  logic [23:0] vivo_inimigo;
  logic        vivo_jogador;
  logic [9:0]  posX_Nave;
  logic        tiro_ativo_inimigo;
  logic [9:0]  posX_Municao2;
  logic [9:0]  posY_Municao2;
  logic        hit_jogador;
  logic [7:0]  R, G, B;

  enemy_shot dut (
    .clk                (clk),
    .reset              (reset),
    .h_counter          (h_counter),
    .v_counter          (v_counter),
    .vivo_inimigo       (vivo_inimigo),
    .vivo_jogador       (vivo_jogador),
    .posX_Nave          (posX_Nave),
    .tiro_ativo_inimigo (tiro_ativo_inimigo),
    .posX_Municao2      (posX_Municao2),
    .posY_Municao2      (posY_Municao2),
    .hit_jogador        (hit_jogador),
    .R                  (R),
    .G                  (G),
    .B                  (B)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int x; int y; int hit;} ev_t;  // kind: 0 spawn, 1 move, 2 end
  typedef struct {int cyc; int rgb;} px_t;
  ev_t evq[$];
  px_t pxq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int m_idle   = 0;
  bit m_active = 1'b0;
  int m_x      = 0;
  int m_y      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic bit overlaps(input int sx, input int sy, input int nx);
    return (sx < nx + PW) && (sx + SW > nx) && (sy < PY + PH) && (sy + SHH > PY);
  endfunction

  // Frame-level reference: what one frame tick does to the shot.
  task automatic model_tick();
    int col, k;
    if (!vivo_jogador) return;
    if (!m_active) begin
      m_idle++;
      if (m_idle == CD) begin
        m_idle = 0;
        col = -1;
        for (int c = 0; c < 8; c++)
          if (col < 0 && (vivo_inimigo[c] || vivo_inimigo[8+c] || vivo_inimigo[16+c])) col = c;
        if (col >= 0) begin
          k = vivo_inimigo[16+col] ? 2 : (vivo_inimigo[8+col] ? 1 : 0);
          m_x = 180 + col * 80 + 20 - 2;
          m_y = 40 + k * 50 + 30;
          m_active = 1'b1;
          evq.push_back('{0, m_x, m_y, 0});
        end
      end
    end else if (m_y + SPEED >= SH) begin
      m_active = 1'b0;
      evq.push_back('{2, 0, 0, 0});
    end else begin
      m_y += SPEED;
      evq.push_back('{1, m_x, m_y, 0});
      if (overlaps(m_x, m_y, int'(posX_Nave))) begin
        m_active = 1'b0;
        evq.push_back('{2, 0, 0, 1});
      end
    end
  endtask

  // Entered and left at posedge+1; one frame tick, then 11 quiet clks.
  task automatic tick();
    model_tick();
    v_counter = 10'd480;
    @(posedge clk); #1;
    v_counter = 10'd100;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("active_track", int'(tiro_ativo_inimigo), int'(m_active));
    @(posedge clk); #1;
  endtask

  task automatic sweep();
    int exp;
    for (int dv = -2; dv < SHH + 2; dv++) begin
      for (int dh = -2; dh < SW + 2; dh++) begin
        h_counter = 10'(m_x + dh);
        v_counter = 10'(m_y + dv);
        exp = (dh >= 0 && dh < SW && dv >= 0 && dv < SHH) ? COLR : 0;
        pxq.push_back('{cyc, exp});
        @(posedge clk); #1;
      end
    end
    v_counter = 10'd100;
  endtask

  task automatic drop_player();
    h_counter    = 10'(m_x);
    v_counter    = 10'(m_y);
    vivo_jogador = 1'b0;
    if (m_active) evq.push_back('{2, 0, 0, 0});
    m_active = 1'b0;
    m_idle   = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rgb_on_drop", int'({R, G, B}), 0);
    @(posedge clk); #1;
    v_counter = 10'd100;
  endtask

  task automatic run_shot(input bit do_sweep, input int drop_after);
    int guard;
    guard = 0;
    while (!m_active && guard < 200) begin tick(); guard++; end
    if (do_sweep && m_active) sweep();
    guard = 0;
    while (m_active && guard < 200) begin
      if (drop_after > 0 && guard == drop_after) begin
        drop_player();
        repeat (3) tick();
        vivo_jogador = 1'b1;
      end else begin
        tick();
      end
      guard++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  bit p_act = 1'b0;
  int p_y   = 0;
  ev_t e;
  px_t p;

  always @(negedge clk) begin
    if (reset) begin
      p_act = 1'b0;
    end else begin
      if (tiro_ativo_inimigo && !p_act) begin
        chk("spawn_expected", int'(evq.size() != 0), 1);
        if (evq.size() != 0) begin
          e = evq.pop_front();
          chk("spawn_kind", 0, e.kind);
          chk("spawn_x", int'(posX_Municao2), e.x);
          chk("spawn_y", int'(posY_Municao2), e.y);
        end
      end else if (tiro_ativo_inimigo && int'(posY_Municao2) != p_y) begin
        chk("move_expected", int'(evq.size() != 0), 1);
        if (evq.size() != 0) begin
          e = evq.pop_front();
          chk("move_kind", 1, e.kind);
          chk("move_y", int'(posY_Municao2), e.y);
        end
      end
      if (!tiro_ativo_inimigo && p_act) begin
        chk("end_expected", int'(evq.size() != 0), 1);
        if (evq.size() != 0) begin
          e = evq.pop_front();
          chk("end_kind", 2, e.kind);
          chk("end_hit", int'(hit_jogador), e.hit);
        end
      end
      if (hit_jogador) chk("hit_only_at_end", int'(p_act && !tiro_ativo_inimigo), 1);
      while (pxq.size() != 0 && pxq[0].cyc == cyc - 1) begin
        p = pxq.pop_front();
        chk("pixel_rgb", int'({R, G, B}), p.rgb);
      end
      p_act = tiro_ativo_inimigo;
      p_y   = int'(posY_Municao2);
    end
  end

  initial begin
    int col, rows, sx, nx, drop;
    reset        = 1'b1;
    h_counter    = 10'd0;
    v_counter    = 10'd100;
    vivo_inimigo = 24'h0;
    vivo_jogador = 1'b1;
    posX_Nave    = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_active", int'(tiro_ativo_inimigo), 0);
    chk("rst_hit", int'(hit_jogador), 0);
    chk("rst_posx", int'(posX_Municao2), 0);
    chk("rst_posy", int'(posY_Municao2), 0);
    chk("rst_rgb", int'({R, G, B}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    repeat (70) tick();

    vivo_inimigo = 24'h1 << 21;
    run_shot(1'b0, 0);

    posX_Nave = 10'd580;
    run_shot(1'b0, 0);

    posX_Nave    = 10'd0;
    vivo_inimigo = (24'h1 << 5) | (24'h1 << 13);
    run_shot(1'b1, 0);

    vivo_inimigo = 24'h1 << 21;
    run_shot(1'b0, 10);
    run_shot(1'b1, 0);

    for (int it = 0; it < 6; it++) begin
      col  = $urandom_range(0, 7);
      rows = $urandom_range(1, 7);
      vivo_inimigo = 24'h0;
      for (int r = 0; r < 3; r++) if (rows[r]) vivo_inimigo[r*8+col] = 1'b1;
      sx = 198 + 80 * col;
      nx = sx - 45 + $urandom_range(0, 55);
      posX_Nave = 10'(nx);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      run_shot(it[0], drop);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("event_queue_drained", evq.size(), 0);
    chk("pixel_queue_drained", pxq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/enemy_shot.md
Name: enemy_shot

Overview:
- Enemy-side counterpart of the player's ammunition block: fires downward shots from the enemy grid at the player ship.
- Picks a random living column and spawns the shot under that column's lowest living enemy.
- Moves the shot once per frame, detects a hit on the player, and supplies the shot's pixel colour to the top-level colour OR-merge.
- Instanced in the game top level beside nave and the player ammunition block.

Parameters:
- ENEMY_W, 40, enemy sprite width in pixels
- ENEMY_H, 30, enemy sprite height in pixels
- SHOT_W, 4, shot width in pixels
- SHOT_H, 12, shot height in pixels
- SHOT_SPEED, 4, pixels moved down per frame
- COOLDOWN_FRAMES, 60, frames between shot opportunities
- PLAYER_Y, 440, player ship top edge (row)
- PLAYER_W, 40, player ship width
- PLAYER_H, 20, player ship height
- COLOR, 24'hFF4040, shot RGB colour

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- h_counter  in  10  VGA pixel column
- v_counter  in  10  VGA pixel row
- vivo_inimigo  in  24  enemy alive mask, bit k*8+i = row k, column i
- vivo_jogador  in  1  player alive; low forces the block idle
- posX_Nave  in  10  player ship left edge
- tiro_ativo_inimigo  out  1  shot in flight
- posX_Municao2  out  10  shot left edge
- posY_Municao2  out  10  shot top edge
- hit_jogador  out  1  one-clk pulse when the shot hits the player
- R, G, B  out  8 each  shot pixel colour, 0 outside the shot

Behaviour:
- Reset (synchronous, active-high): all outputs 0; state IDLE; cooldown = COOLDOWN_FRAMES; LFSR = 16'hACE1.
- frame_tick: one-clk internal pulse, asserted when registered v_counter != 480 and current v_counter == 480. This gives one pulse per frame, independent of the 25 MHz pixel rate.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk.
- IDLE:
  - Decrement cooldown on frame_tick.
  - On the tick where cooldown is 0, go to SELECT and latch col = lfsr[2:0].
- SELECT: scans one column per clk, starting at col, wrapping 7 -> 0, at most 8 clks.
  - The alive mask is sampled during each column's scan cycle.
  - First column with any alive bit: pick the highest alive row k.
  - Load posX = 180 + col*80 + ENEMY_W/2 - SHOT_W/2.
  - Load posY = 40 + k*50 + ENEMY_H.
  - Go to FLY; tiro_ativo_inimigo rises the same edge.
  - No column alive after 8 clks: back to IDLE, cooldown reloaded, no shot.
- FLY, on each frame_tick:
  - If posY + SHOT_SPEED >= 480 (computed 11-bit, no wrap): go to IDLE, clear active, reload cooldown.
  - Otherwise posY += SHOT_SPEED, then test overlap with the new posY.
  - Overlap condition, all strict: posX < posX_Nave+PLAYER_W, posX+SHOT_W > posX_Nave, posY < PLAYER_Y+PLAYER_H, posY+SHOT_H > PLAYER_Y.
  - Overlap true: go to HIT.
- HIT: hit_jogador = 1 for exactly one clk, active cleared, cooldown reloaded, then IDLE.
- vivo_jogador low in any state: next edge go to IDLE, active = 0, no hit pulse, cooldown reloaded. The block stays in IDLE while vivo_jogador is low.
- Reset mid-flight: shot cleared at the same edge, no hit pulse.
- Pixel output:
  - Registered, 1-clk latency.
  - RGB = COLOR when active, posX <= h_counter < posX+SHOT_W, and posY <= v_counter < posY+SHOT_H.
  - Otherwise RGB = 0.
- Only one shot exists at a time.

Decomposition:
- Shared package:
  - Grid constants: GRID_X0=180, GRID_DX=80, GRID_Y0=40, GRID_DY=50, GRID_COLS=8, GRID_ROWS=3.
  - SCREEN_H=480.
  - State enum: IDLE, SELECT, FLY, HIT.
  - These are shared with the enemy grid and player ammo blocks.
- Sub-module lfsr16 (clk, reset, out[15:0]), reused by future enemy-movement randomness.

Test Plan:
- Reset, vivo_jogador=1, mask=24'h0, tick frames -> after 60 ticks SELECT lasts exactly 8 clks, returns to IDLE, tiro_ativo_inimigo stays 0.
- Mask = only bit 21 (row 2, col 5), posX_Nave=0 -> after 60 ticks shot spawns at posX=598, posY=170; posY increments by 4 per tick. At posY=478, the 78th tick clears active with no hit_jogador.
- Same spawn, posX_Nave=580 -> on the 65th tick after spawn (posY=430), hit_jogador pulses for exactly 1 clk and active clears.
- Mask = bits 5 and 13 (col 5, rows 0 and 1) -> spawn posY=120 (row 1 chosen, lowest alive).
- Drop vivo_jogador mid-flight -> next edge active=0, RGB=0, no hit. Raise it again -> next shot only after 60 more ticks.
- During flight, drive h/v counters over the shot rectangle -> RGB = FF/40/40 one clk later inside the rectangle. Pixels at h=posX+4 and v=posY+12 read 0.
